bcd_converter: RTL and testbench
================================

BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, as the binary input width.
REQ-002 The block SHALL take parameter MAX_VAL, default 9999, as the largest value representable on four decimal digits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port num, input, WIDTH bits: the unsigned binary value to convert.
REQ-006 The block SHALL have port valid_in, input, 1 bit: num is presented for conversion.
REQ-007 The block SHALL have port ready, output, 1 bit: the block can accept a new value.
REQ-008 The block SHALL have port bcd, output, 16 bits: digits [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-009 The block SHALL have port ovf, output, 1 bit: the last accepted num exceeded MAX_VAL.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking a new bcd/ovf result.

Function
REQ-011 A value SHALL be accepted on a rising edge where valid_in=1 and ready=1; valid_in SHALL be ignored while ready=0.
REQ-012 The state machine SHALL have three states:
- IDLE: ready=1.
- SHIFT: ready=0.
- DONE: ready=0, done=1.
REQ-013 On acceptance, the block SHALL:
- load a 14-bit shift register with min(num, MAX_VAL);
- clear the BCD working register;
- clear the shift counter;
- register ovf_pending = (num > MAX_VAL);
- enter SHIFT.
REQ-014 Each edge in SHIFT SHALL first add 3 (4-bit, no carry out) to every working nibble >= 5, then left-shift the working and shift registers together by one bit, and then increment the counter.
REQ-015 Exactly 14 shifts SHALL occur, on edges T+1..T+14, where T is the accepting edge.
REQ-016 At edge T+14 the block SHALL load the final working value into bcd, load ovf_pending into ovf, and enter DONE.
REQ-017 done SHALL be 1 only in the cycle after T+14; edge T+15 SHALL return the block to IDLE.
REQ-018 If valid_in is held high continuously, the next acceptance SHALL occur at edge T+16, giving one result per 16 cycles.
REQ-019 bcd and ovf SHALL hold their last result and change only at the DONE-entry edge; they SHALL never show intermediate shift data.
REQ-020 num > MAX_VAL SHALL produce bcd = 9999 and ovf = 1.
REQ-021 num <= MAX_VAL SHALL produce the exact decimal digits and ovf = 0.
REQ-022 num SHALL be sampled only at the accepting edge; later changes to num SHALL not affect the running conversion.
REQ-023 Each BCD nibble SHALL remain within 0..9 after every shift step.

Reset
REQ-024 While rst_n=0, the block SHALL immediately, without waiting for clk, force the following:
- state IDLE;
- ready=1;
- done=0;
- bcd=16'h0000;
- ovf=0;
- counter, shift register and working register all zero.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no done pulse and no change to bcd beyond clearing it.
REQ-026 The first acceptance after reset SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 A shared package bcd_pkg SHALL hold the following constants and type:
- the state enumeration (IDLE, SHIFT, DONE);
- SHIFT_BITS=14;
- DIGITS=4;
- the default MAX_VAL.
REQ-028 The nibble adjustment SHALL be a combinational sub-module bcd_add3 (4-bit in, 4-bit out, adds 3 when the input is >= 5), instantiated four times.
REQ-029 The bcd output SHALL be directly consumable as four nibbles by the downstream seven-segment multiplexer.

Verification
REQ-030 Scenario 1: num=1234 accepted at edge T -> done high only in cycle after T+14, bcd=16'h1234, ovf=0, ready low T+1..T+15.
REQ-031 Scenario 2: num=0, then num=9999 -> bcd=16'h0000, then bcd=16'h9999, ovf=0 for both.
REQ-032 Scenario 3: num=10000, then num=65535 -> bcd=16'h9999 and ovf=1 for each.
REQ-033 Scenario 4: valid_in held high with num=42 then 7 -> accepts at T and T+16; results 16'h0042 then 16'h0007; valid_in during SHIFT/DONE ignored.
REQ-034 Scenario 5: rst_n pulsed low at T+7 of a 5678 conversion -> outputs reset immediately, no done pulse; a subsequent 5678 yields 16'h5678.
REQ-035 Scenario 6: num changed to 9 at T+3 during a 321 conversion -> result 16'h0321.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and types for the binary-to-BCD converter.
//   state_t          : converter FSM states (IDLE, SHIFT, DONE)
//   SHIFT_BITS       : width of the binary shift register (holds up to 9999)
//   DIGITS           : number of BCD digits produced
//   BCD_W            : total BCD output width (four bits per digit)
//   CNT_W            : width of the shift counter (counts 0..SHIFT_BITS-1)
//   DEFAULT_MAX_VAL  : largest value representable on DIGITS decimal digits
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SHIFT_BITS      = 14;
  localparam int DIGITS          = 4;
  localparam int BCD_W           = 4 * DIGITS;
  localparam int CNT_W           = 4;
  localparam int DEFAULT_MAX_VAL = 9999;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
// Ports:
//   nib : input  [3:0] BCD digit before the shift
//   adj : output [3:0] corrected digit (no carry out)
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  always_comb begin
    adj = nib;
    if (nib >= 4'd5) begin
      adj = nib + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one result every
// 16 cycles. Inputs above MAX_VAL saturate to 9999 and raise ovf.
// Ports:
//   clk      : input            clock, rising edge
//   rst_n    : input            asynchronous active-low reset
//   num      : input  [WIDTH-1:0] unsigned binary value
//   valid_in : input            num is presented for conversion
//   ready    : output           converter idle, can accept num
//   bcd      : output [15:0]    thousands/hundreds/tens/ones nibbles
//   ovf      : output           last accepted num exceeded MAX_VAL
//   done     : output           one-cycle pulse marking a new bcd/ovf
module bcd_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MAX_VAL = DEFAULT_MAX_VAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] num,
  input  logic             valid_in,
  output logic             ready,
  output logic [BCD_W-1:0] bcd,
  output logic             ovf,
  output logic             done
);

  // Clamp the input to the range that fits on four decimal digits.
  function automatic logic [SHIFT_BITS-1:0] sat_val(input logic [WIDTH-1:0] v);
    if (32'(v) > 32'(MAX_VAL)) begin
      return SHIFT_BITS'(MAX_VAL);
    end
    return SHIFT_BITS'(v);
  endfunction

  function automatic logic is_over(input logic [WIDTH-1:0] v);
    return (32'(v) > 32'(MAX_VAL));
  endfunction

  state_t                state_q;
  state_t                state_d;
  logic [SHIFT_BITS-1:0] shift_q;
  logic [SHIFT_BITS-1:0] shift_next;
  logic [BCD_W-1:0]      work_q;
  logic [BCD_W-1:0]      work_adj;
  logic [BCD_W-1:0]      work_next;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ovf_pend_q;
  logic                  accept;
  logic                  last_shift;

  assign accept     = (state_q == IDLE) && valid_in;
  assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(SHIFT_BITS - 1));

  // Correct every digit, then shift working and binary registers as one
  // concatenated value; the bit shifted out of the top is always zero
  // because the clamped input never exceeds 9999.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .nib (work_q[4*g +: 4]),
      .adj (work_adj[4*g +: 4])
    );
  end

  assign {work_next, shift_next} = {work_adj, shift_q} << 1;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (valid_in)   state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = (state_q == IDLE);
    done  = (state_q == DONE);
  end

  // Datapath: conversion registers and the held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd        <= '0;
      ovf        <= 1'b0;
    end else if (accept) begin
      shift_q    <= sat_val(num);
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= is_over(num);
    end else if (state_q == SHIFT) begin
      shift_q <= shift_next;
      work_q  <= work_next;
      cnt_q   <= cnt_q + CNT_W'(1);
      // Result registers only move on the final shift so the outputs
      // never expose partial conversions.
      if (last_shift) begin
        bcd <= work_next;
        ovf <= ovf_pend_q;
      end
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
module tb_bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] num = '0;
  logic        valid_in = 1'b0;
  logic        ready;
  logic [15:0] bcd;
  logic        ovf;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Expected results: {bcd, ovf}
  logic [16:0] sb[$];

  bcd_converter #(.WIDTH(16), .MAX_VAL(9999)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .num      (num),
    .valid_in (valid_in),
    .ready    (ready),
    .bcd      (bcd),
    .ovf      (ovf),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual bcd=%0h ovf=%0b required no pulse", bcd, ovf);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("result_bcd", 32'(bcd), 32'(e[16:1]));
        chk("result_ovf", 32'(ovf), 32'(e[0]));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready actual ready=0 required ready=1 within 40 cycles");
    end
  endtask

  // Issue one conversion and wait until the block is idle again.
  task automatic do_conv(input logic [15:0] v, input logic [15:0] exp_bcd, input logic exp_ovf);
    wait_ready();
    num      = v;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sb.push_back({exp_bcd, exp_ovf});
    chk("accept_ready_low", 32'(ready), 32'd0);
    wait_ready();
  endtask

  initial begin
    // Reset state, visible before any clock edge
    #2;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_bcd",   32'(bcd),   32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Scenario 1: cycle-accurate timing of a 1234 conversion
    wait_ready();
    num      = 16'd1234;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sb.push_back({16'h1234, 1'b0});
    chk("s1_ready_T", 32'(ready), 32'd0);
    chk("s1_done_T",  32'(done),  32'd0);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      if (k <= 14) begin
        chk($sformatf("s1_ready_T+%0d", k), 32'(ready), 32'd0);
        chk($sformatf("s1_done_T+%0d", k), 32'(done), (k == 14) ? 32'd1 : 32'd0);
      end else begin
        chk("s1_ready_T+15", 32'(ready), 32'd1);
        chk("s1_done_T+15",  32'(done),  32'd0);
      end
      if (k <= 13) begin
        chk($sformatf("s1_bcd_hold_T+%0d", k), 32'(bcd), 32'd0);
      end
    end

    // Scenario 2: range endpoints
    do_conv(16'd0,    16'h0000, 1'b0);
    do_conv(16'd9999, 16'h9999, 1'b0);

    // Scenario 3: saturation
    do_conv(16'd10000, 16'h9999, 1'b1);
    do_conv(16'd65535, 16'h9999, 1'b1);
    do_conv(16'd8,     16'h0008, 1'b0);

    // Scenario 4: valid_in held high, back-to-back acceptances 16 apart
    wait_ready();
    num      = 16'd42;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back({16'h0042, 1'b0});
    num = 16'd7;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    chk("s4_ready_T+15", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    sb.push_back({16'h0007, 1'b0});
    chk("s4_ready_T+16", 32'(ready), 32'd0);
    valid_in = 1'b0;
    wait_ready();

    // Scenario 6: num changes mid-conversion
    wait_ready();
    num      = 16'd321;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sb.push_back({16'h0321, 1'b0});
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    num = 16'd9;
    wait_ready();

    // Scenario 5: reset mid-conversion aborts with no done pulse
    wait_ready();
    num      = 16'd5678;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sb.push_back({16'h5678, 1'b0});
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("s5_rst_bcd",   32'(bcd),   32'd0);
    chk("s5_rst_ovf",   32'(ovf),   32'd0);
    chk("s5_rst_ready", 32'(ready), 32'd1);
    chk("s5_rst_done",  32'(done),  32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_conv(16'd5678, 16'h5678, 1'b0);

    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
